// File: rtl/moving_avg_reader.sv
// moving_avg_reader
// Pulls two's-complement samples one at a time from an upstream FIFO. It keeps
// the last TAPS samples in a shift register. Once TAPS samples have arrived
// since the last reset or flush, it presents the floor average of the window
// on a valid/ready output. It then waits for that output to be taken before
// it issues the next read.
//
// State table:
//   state | meaning
//   IDLE  | wait for the FIFO to hold data
//   READ  | issue a single fifo_rden strobe
//   WAIT  | FIFO returns the data; shift it into the history at cycle end
//   CALC  | bump the fill count; register the average once the window is full
//   OUT   | present out_data until out_ready takes it
//
// Ports:
//   fifo_clk    : single clock, rising edge
//   rst         : synchronous active-high reset
//   fifo_empty  : upstream FIFO has no data
//   fifo_rddata : upstream read data, valid the cycle after fifo_rden
//   fifo_rden   : read strobe to the upstream FIFO
//   flush       : clear the history and start priming again
//   out_ready   : downstream accepts out_data
//   out_valid   : out_data holds a valid average
//   out_data    : floor average of the last TAPS samples
//   primed      : TAPS samples are in the history
module moving_avg_reader #(
    parameter int DATA_W = 16,
    parameter int TAPS   = 4
) (
    input  logic              fifo_clk,
    input  logic              rst,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_rddata,
    output logic              fifo_rden,
    input  logic              flush,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              primed
);

    localparam int         SUM_W    = DATA_W + 2;
    localparam logic [2:0] FILL_MAX = 3'(TAPS);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        CALC,
        OUT
    } state_t;

    state_t            state;
    state_t            state_d;
    logic              rden;
    logic [DATA_W-1:0] hist [TAPS];
    logic [2:0]        fill_cnt;
    logic [2:0]        fill_inc;
    logic [SUM_W-1:0]  sum;
    logic [DATA_W-1:0] avg;
    logic [1:0]        sum_frac_unused;

    assign fill_inc = (fill_cnt >= FILL_MAX) ? FILL_MAX : fill_cnt + 3'd1;

    // Sign-extend each sample by two bits. Four DATA_W-bit values cannot
    // overflow DATA_W+2 bits.
    always_comb begin
        sum = '0;
        for (int i = 0; i < TAPS; i++) begin
            sum = sum + {{2{hist[i][DATA_W-1]}}, hist[i]};
        end
    end

    // Dropping the two LSBs of the sign-extended sum is an arithmetic shift
    // right by 2. This rounds toward minus infinity, so -1/4 gives -1.
    assign avg             = sum[SUM_W-1:2];
    assign sum_frac_unused = sum[1:0];

    always_comb begin
        state_d = state;
        rden    = 1'b0;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) state_d = READ;
                end
                READ: begin
                    // Guard against the FIFO emptying between IDLE and READ.
                    if (!fifo_empty) begin
                        rden    = 1'b1;
                        state_d = WAIT;
                    end else begin
                        state_d = IDLE;
                    end
                end
                WAIT: state_d = CALC;
                CALC: state_d = (fill_inc == FILL_MAX) ? OUT : IDLE;
                OUT: begin
                    if (out_ready) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Flush is already folded into rden. Reset blocks a new read from being
    // issued in the same cycle.
    assign fifo_rden = rden & ~rst;

    always_ff @(posedge fifo_clk) begin
        if (rst) begin
            state     <= IDLE;
            fill_cnt  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            primed    <= 1'b0;
            for (int i = 0; i < TAPS; i++) hist[i] <= '0;
        end else begin
            state     <= state_d;
            out_valid <= (state_d == OUT);
            if (flush) begin
                fill_cnt <= '0;
                primed   <= 1'b0;
                for (int i = 0; i < TAPS; i++) hist[i] <= '0;
            end else begin
                if (state == WAIT) begin
                    hist[0] <= fifo_rddata;
                    for (int i = 1; i < TAPS; i++) hist[i] <= hist[i-1];
                end
                if (state == CALC) begin
                    fill_cnt <= fill_inc;
                    primed   <= (fill_inc == FILL_MAX);
                    if (fill_inc == FILL_MAX) out_data <= avg;
                end
            end
        end
    end

endmodule

// File: tb/tb_moving_avg_reader.sv
// Bench for moving_avg_reader. A FIFO model feeds samples from a queue.
// Every sample the DUT actually consumes goes into a window-level reference
// model, which queues the expected averages. A monitor compares each output
// handshake against that queue and watches the protocol rules.
module tb_moving_avg_reader;

    localparam int DATA_W = 16;

    logic              fifo_clk = 1'b0;
    logic              rst = 1'b1;
    logic              fifo_empty = 1'b1;
    logic [DATA_W-1:0] fifo_rddata = '0;
    logic              fifo_rden;
    logic              flush = 1'b0;
    logic              out_ready = 1'b1;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              primed;

    moving_avg_reader #(.DATA_W(DATA_W), .TAPS(4)) dut (
        .fifo_clk    (fifo_clk),
        .rst         (rst),
        .fifo_empty  (fifo_empty),
        .fifo_rddata (fifo_rddata),
        .fifo_rden   (fifo_rden),
        .flush       (flush),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .primed      (primed)
    );

    always #5 fifo_clk = ~fifo_clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [DATA_W-1:0] src_q[$];
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] window[$];

    bit                force_empty = 1'b0;
    bit                rd_pend = 1'b0;
    logic [DATA_W-1:0] rd_data = '0;
    int                cyc = 0;
    int                last_rden_cyc = -100;
    int                hs_cnt = 0;
    logic [DATA_W-1:0] last_out = '0;

    task automatic check(input bit ok, input string name,
                         input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    // Reference: floor mean of the last four consumed samples, taken as
    // signed integers.
    function automatic void model_accept(input logic [DATA_W-1:0] d);
        int s;
        window.push_back(d);
        if (window.size() > 4) void'(window.pop_front());
        if (window.size() == 4) begin
            s = 0;
            foreach (window[i]) s += int'($signed(window[i]));
            exp_q.push_back(DATA_W'(s >>> 2));
        end
    endfunction

    // FIFO model. Data appears the cycle after the read strobe, and empty
    // updates after the read edge.
    initial begin : fifo_model
        forever begin
            @(negedge fifo_clk);
            if (rd_pend) begin
                if (!rst && !flush) model_accept(rd_data);
                rd_pend = 1'b0;
            end
            if (rst || flush) window.delete();
            if (fifo_rden) begin
                if (src_q.size() == 0) begin
                    check(1'b0, "read_from_empty_queue", 1, 0);
                end else begin
                    rd_data = src_q.pop_front();
                    rd_pend = 1'b1;
                end
            end
            @(posedge fifo_clk);
            #2;
            fifo_rddata = rd_pend ? rd_data : DATA_W'($urandom);
            fifo_empty  = force_empty || (src_q.size() == 0);
        end
    end

    initial begin : monitor
        bit                prev_valid = 1'b0;
        bit                prev_ready = 1'b0;
        bit                prev_abort = 1'b1;
        logic [DATA_W-1:0] prev_data = '0;
        logic [DATA_W-1:0] e;
        forever begin
            @(negedge fifo_clk);
            cyc++;
            if (fifo_rden) begin
                check(!fifo_empty, "rden_while_empty", 32'(fifo_empty), 0);
                last_rden_cyc = cyc;
            end
            if (out_valid && !prev_valid)
                check(cyc - last_rden_cyc == 3, "rden_to_valid_latency",
                      32'(cyc - last_rden_cyc), 3);
            if (prev_valid && !prev_ready && !prev_abort) begin
                check(out_valid, "bp_valid_held", 32'(out_valid), 1);
                check(out_data == prev_data, "bp_data_stable", out_data, prev_data);
                check(!fifo_rden, "bp_no_read", 32'(fifo_rden), 0);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check(1'b0, "unexpected_output", out_data, 0);
                end else begin
                    e = exp_q.pop_front();
                    check(out_data == e, "avg_value", out_data, e);
                end
                check(primed, "primed_at_output", 32'(primed), 1);
                hs_cnt++;
                last_out = out_data;
            end
            prev_valid = out_valid;
            prev_ready = out_ready;
            prev_data  = out_data;
            prev_abort = rst || flush;
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic drain();
        int n = 0;
        do begin
            @(negedge fifo_clk);
            n++;
        end while (n < 3000 && !(src_q.size() == 0 && !rd_pend &&
                   exp_q.size() == 0 && !out_valid && !fifo_rden));
        check(n < 3000, "drain_timeout", n, 3000);
        repeat (3) @(negedge fifo_clk);
    endtask

    task automatic push4(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                         input logic [DATA_W-1:0] c, input logic [DATA_W-1:0] d);
        src_q.push_back(a);
        src_q.push_back(b);
        src_q.push_back(c);
        src_q.push_back(d);
    endtask

    task automatic pulse(input bit use_rst);
        @(posedge fifo_clk);
        #1;
        if (use_rst) rst = 1'b1; else flush = 1'b1;
        @(posedge fifo_clk);
        #1;
        rst   = 1'b0;
        flush = 1'b0;
    endtask

    // Abort an in-flight read during its WAIT cycle with reset or flush.
    // Four fresh samples must then be needed before the next output.
    task automatic abort_in_wait(input bit use_rst, input string tag);
        int n;
        int hs0;
        src_q.push_back(16'h7777);
        n = 0;
        do begin
            @(negedge fifo_clk);
            n++;
        end while (!fifo_rden && n < 30);
        check(n < 30, {tag, "_read_seen"}, n, 30);
        pulse(use_rst);
        @(negedge fifo_clk);
        check(!out_valid, {tag, "_valid_cleared"}, 32'(out_valid), 0);
        check(!primed, {tag, "_primed_cleared"}, 32'(primed), 0);
        if (use_rst) check(out_data == 0, {tag, "_data_cleared"}, out_data, 0);
        hs0 = hs_cnt;
        src_q.push_back(16'd100);
        src_q.push_back(16'd200);
        src_q.push_back(16'd300);
        drain();
        check(hs_cnt == hs0, {tag, "_no_out_before_4"}, hs_cnt, hs0);
        src_q.push_back(16'd400);
        drain();
        check(hs_cnt == hs0 + 1, {tag, "_out_after_4"}, hs_cnt, hs0 + 1);
        check(last_out == 16'd250, {tag, "_avg"}, last_out, 250);
    endtask

    initial begin : stimulus
        int n;
        int hs0;
        int rd_seen;
        logic [DATA_W-1:0] held;

        repeat (3) @(posedge fifo_clk);
        #1 rst = 1'b0;
        @(negedge fifo_clk);
        check(!out_valid, "reset_out_valid", 32'(out_valid), 0);
        check(!primed, "reset_primed", 32'(primed), 0);
        check(out_data == 0, "reset_out_data", out_data, 0);
        check(!fifo_rden, "reset_rden", 32'(fifo_rden), 0);

        // Priming and sliding window
        push4(16'd4, 16'd8, 16'd12, 16'd16);
        drain();
        check(hs_cnt == 1, "prime_single_output", hs_cnt, 1);
        check(last_out == 16'd10, "prime_avg", last_out, 10);
        check(primed, "primed_set", 32'(primed), 1);
        src_q.push_back(16'd20);
        drain();
        check(last_out == 16'd14, "slide_avg_20", last_out, 14);
        src_q.push_back(16'd24);
        drain();
        check(last_out == 16'd18, "slide_avg_24", last_out, 18);

        // Signed floor after flush
        pulse(1'b0);
        @(negedge fifo_clk);
        check(!primed, "flush_primed", 32'(primed), 0);
        push4(16'hFFFF, 16'h0000, 16'h0000, 16'h0000);
        drain();
        check(last_out == 16'hFFFF, "floor_minus_quarter", last_out, 16'hFFFF);
        push4(16'hFFFC, 16'hFFFC, 16'hFFFC, 16'hFFFC);
        drain();
        check(last_out == 16'hFFFC, "neg_avg", last_out, 16'hFFFC);

        // Backpressure
        @(posedge fifo_clk);
        #1 out_ready = 1'b0;
        push4(16'd40, 16'd40, 16'd40, 16'd40);
        src_q.push_back(16'd40);
        n = 0;
        do begin
            @(negedge fifo_clk);
            n++;
        end while (!out_valid && n < 50);
        check(n < 50, "bp_valid_seen", n, 50);
        held = out_data;
        rd_seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge fifo_clk);
            if (fifo_rden) rd_seen++;
            check(out_data == held, "bp_held_value", out_data, held);
        end
        check(rd_seen == 0, "bp_read_count", rd_seen, 0);
        check(out_valid, "bp_still_valid", 32'(out_valid), 1);
        check(!fifo_empty, "bp_fifo_nonempty", 32'(fifo_empty), 0);
        hs0 = hs_cnt;
        @(posedge fifo_clk);
        #1 out_ready = 1'b1;
        @(negedge fifo_clk);
        #1;
        check(hs_cnt == hs0 + 1, "bp_one_handshake", hs_cnt, hs0 + 1);
        n = 0;
        do begin
            @(negedge fifo_clk);
            n++;
        end while (!fifo_rden && n < 10);
        check(n < 10, "bp_reading_resumes", n, 10);
        drain();

        // Empty handling
        @(posedge fifo_clk);
        #1 force_empty = 1'b1;
        src_q.push_back(16'd1);
        src_q.push_back(16'd2);
        rd_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge fifo_clk);
            if (fifo_rden) rd_seen++;
        end
        check(rd_seen == 0, "empty_no_read", rd_seen, 0);
        check(!out_valid, "empty_idle", 32'(out_valid), 0);
        @(posedge fifo_clk);
        #1 force_empty = 1'b0;
        @(negedge fifo_clk);
        check(!fifo_rden, "empty_release_same_cycle", 32'(fifo_rden), 0);
        @(negedge fifo_clk);
        check(fifo_rden, "empty_release_next_cycle", 32'(fifo_rden), 1);
        drain();

        // Reset and flush in the middle of a read
        abort_in_wait(1'b1, "rst_wait");
        abort_in_wait(1'b0, "flush_wait");

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            @(posedge fifo_clk);
            #1;
            out_ready   = ($urandom_range(0, 3) != 0);
            force_empty = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 2) == 0) src_q.push_back(DATA_W'($urandom));
        end
        @(posedge fifo_clk);
        #1;
        out_ready   = 1'b1;
        force_empty = 1'b0;
        drain();
        check(exp_q.size() == 0, "all_expected_seen", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/moving_avg_reader.md
MOVING_AVG_READER -- requirements
Module: moving_avg_reader

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning the sample width in bits (two's complement).
REQ-002 The block SHALL have parameter TAPS, default 4, meaning the moving-average window, fixed at 4 in this revision.
REQ-003 The block SHALL have port fifo_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port fifo_empty, input, 1 bit: upstream FIFO holds no data.
REQ-006 The block SHALL have port fifo_rddata, input, DATA_W bits: upstream FIFO read data, valid exactly one cycle after a fifo_rden pulse.
REQ-007 The block SHALL have port fifo_rden, output, 1 bit: read strobe to the upstream FIFO.
REQ-008 The block SHALL have port flush, input, 1 bit: clears the sample history and re-enters priming.
REQ-009 The block SHALL have port out_ready, input, 1 bit: downstream accepts out_data.
REQ-010 The block SHALL have port out_valid, output, 1 bit: out_data holds a valid average.
REQ-011 The block SHALL have port out_data, output, DATA_W bits: the moving average of the last 4 samples.
REQ-012 The block SHALL have port primed, output, 1 bit: high once 4 samples are in the history since the last reset or flush.

Function
REQ-013 The FSM SHALL have states IDLE, READ, WAIT, CALC and OUT.
REQ-014 IDLE SHALL go to READ when fifo_empty=0; otherwise it stays in IDLE.
REQ-015 READ SHALL assert fifo_rden for exactly one cycle, then go to WAIT.
REQ-016 WAIT SHALL capture fifo_rddata into the history shift register (newest in, oldest out) at the end of the cycle, then go to CALC.
REQ-017 CALC SHALL increment a saturating fill count (0..4).
REQ-018 In CALC, if the count after the increment is 4, the block SHALL register out_data and go to OUT; otherwise it SHALL go to IDLE with no output.
REQ-019 The sum SHALL be computed sign-extended to DATA_W+2 bits; out_data SHALL be sum arithmetically shifted right by 2 (floor, no rounding); overflow is impossible.
REQ-020 In OUT, out_valid SHALL be 1; on out_valid and out_ready in the same cycle the FSM SHALL go to IDLE and drop out_valid in the next cycle.
REQ-021 While out_valid=1 and out_ready=0, out_data SHALL be held stable and fifo_rden SHALL stay 0 (backpressure).
REQ-022 fifo_rden SHALL never be asserted when fifo_empty=1 in the same cycle, and at most one read SHALL be outstanding.
REQ-023 Throughput SHALL be at most one sample per 4 cycles; with out_ready tied high and the FIFO never empty, the first out_valid SHALL come 3 cycles after the 4th fifo_rden pulse.
REQ-024 flush SHALL be honoured in any state; it has priority over all other events in the same cycle.
REQ-025 On flush the block SHALL clear the history and fill count, drop out_valid and primed, and go to IDLE.
REQ-026 A read already issued when flush arrives SHALL have its data discarded, and no FIFO read SHALL be lost twice (flush in WAIT drops that sample).
REQ-027 primed SHALL equal (fill count == 4), registered.

Reset
REQ-028 When rst=1 at a clock edge, the block SHALL force state IDLE, history=0, fill count=0, fifo_rden=0, out_valid=0, out_data=0 and primed=0.
REQ-029 Reset SHALL abort any in-flight read; data returned the next cycle SHALL be ignored.
REQ-030 Reset SHALL take precedence over flush.

Verification
REQ-031 The bench SHALL check priming: FIFO supplies 4, 8, 12, 16 -> no out_valid for the first 3 samples; after the 4th, out_data=10, primed=1.
REQ-032 The bench SHALL check the sliding window: continuing from REQ-031, push 20 -> out_data=14; push 24 -> out_data=18.
REQ-033 The bench SHALL check signed floor: after flush, samples 0xFFFF, 0, 0, 0 -> out_data=0xFFFF (-1); samples 0xFFFC×4 -> out_data=0xFFFC.
REQ-034 The bench SHALL check backpressure: hold out_ready=0 for 10 cycles while out_valid=1 with FIFO non-empty -> out_data stable, fifo_rden=0 throughout; release -> one handshake, then reading resumes.
REQ-035 The bench SHALL check empty handling: fifo_empty=1 for 20 cycles -> fifo_rden stays 0, state IDLE; deassert -> fifo_rden pulses next cycle.
REQ-036 The bench SHALL check reset and flush mid-operation: assert rst during WAIT -> all outputs 0 next cycle, the returned sample is ignored, and 4 new samples are needed before out_valid; repeat with flush -> same result.
